dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the CPU data memory.
- Shares the memory between the core load/store path (port 0) and a debug/DMA loader (port 1).
- Issues exactly one MemRead or MemWrite strobe per transaction and returns a one-cycle ack.
- Captures the memory's registered read data and rejects addresses the nibble-packed memory cannot hold.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 34 +++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   state_e           : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   PORT_CPU/PORT_DBG : requester ids (core load/store path, debug/DMA loader)
//   addr_illegal_mask : address bits that must be zero for a word address the
//                       nibble-packed memory can hold (8 nibbles per word)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int unsigned NIBBLES_PER_WORD = 8;
  localparam int unsigned MEM_DEPTH_DEF    = 16;

  // A word occupies NIBBLES_PER_WORD entries, so the low bits must be zero and
  // nothing may reach past the last entry. Only the word-index bits may be set.
  function automatic logic [63:0] addr_illegal_mask(input int unsigned depth);
    logic [63:0] span;
    span = 64'(depth - 1);
    return ~(span & ~64'(NIBBLES_PER_WORD - 1));
  endfunction

  localparam logic [63:0] ADDR_ILLEGAL_MASK_DEF = addr_illegal_mask(MEM_DEPTH_DEF);

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request per port
//   accept     : the current grant is taken; remember it as last winner
//   gnt_any    : at least one request present
//   gnt_id     : winning port id (valid when gnt_any)
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_any,
  output logic       gnt_id
);

  logic rr_last;

  always_comb begin
    gnt_any = |req;
    // On a tie the port that did not win last time goes; otherwise the lone
    // requester wins (req[1] alone selects port 1, anything else port 0).
    if (req == 2'b11) gnt_id = ~rr_last;
    else              gnt_id = req[1];
  end

  // Resetting to PORT_DBG lets the CPU port win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_last <= PORT_DBG;
    else if (accept) rr_last <= gnt_id;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of the CPU data memory.
//   clk, rst_n              : clock, asynchronous active-low reset
//   pN_req/we/addr/wdata    : port N request, held until pN_ack
//   pN_ack/err/rdata        : port N one-cycle completion, address reject, read data
//   mem_addr/wdata          : memory address and write data (registered)
//   mem_write/mem_read      : one-cycle registered strobes, high in ISSUE only
//   mem_rdata               : memory read data, one cycle after mem_read
//   busy                    : sequencer not in IDLE
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [63:0]       ILLEGAL_MASK64 = addr_illegal_mask(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ILLEGAL_MASK   = ILLEGAL_MASK64[ADDR_W-1:0];

  state_e            state_q, state_d;
  logic              take;
  logic              gnt_any, gnt_id;
  logic              sel_we, sel_legal;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              win_id_q, we_q, err_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              resp;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({p1_req, p0_req}),
    .accept  (take),
    .gnt_any (gnt_any),
    .gnt_id  (gnt_id)
  );

  assign sel_we    = (gnt_id == PORT_DBG) ? p1_we    : p0_we;
  assign sel_addr  = (gnt_id == PORT_DBG) ? p1_addr  : p0_addr;
  assign sel_wdata = (gnt_id == PORT_DBG) ? p1_wdata : p0_wdata;
  assign sel_legal = ((sel_addr & ILLEGAL_MASK) == '0);

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          take    = 1'b1;
          state_d = sel_legal ? ISSUE : RESP;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_id_q  <= PORT_CPU;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      // Strobes are only ever set on the IDLE->ISSUE edge, so they last one cycle.
      mem_write <= take & sel_legal & sel_we;
      mem_read  <= take & sel_legal & ~sel_we;
      if (take) begin
        win_id_q <= gnt_id;
        we_q     <= sel_we;
        err_q    <= ~sel_legal;
        // Rejected accesses never touch the memory bus.
        if (sel_legal) begin
          mem_addr  <= sel_addr;
          mem_wdata <= sel_wdata;
        end
      end
      // Memory data is registered, so it is valid during WAIT.
      if (state_q == WAIT && !we_q) begin
        if (win_id_q == PORT_DBG) rdata1_q <= mem_rdata;
        else                      rdata0_q <= mem_rdata;
      end
    end
  end

  assign busy   = (state_q != IDLE);
  assign resp   = (state_q == RESP);
  assign p0_ack = resp & (win_id_q == PORT_CPU);
  assign p1_ack = resp & (win_id_q == PORT_DBG);
  assign p0_err = p0_ack & err_q;
  assign p1_err = p1_ack & err_q;

  // The held read registers are masked to zero only while acking a write or a
  // rejected access; at all other times they show the last read result.
  assign p0_rdata = (p0_ack && (we_q || err_q)) ? '0 : rdata0_q;
  assign p1_rdata = (p1_ack && (we_q || err_q)) ? '0 : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_write, mem_read, busy;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_model [2];

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Word-level model of the registered data memory (word addresses 0 and 8).
  always @(posedge clk) begin
    if (mem_write) mem_model[mem_addr[3]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem_model[mem_addr[3]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; outputs sampled 1 time unit after the edge, plus per-cycle invariants.
  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    if (mem_write && mem_read) begin
      errors++;
      $display("FAIL strobe_excl: mem_write=%b mem_read=%b, required not both 1", mem_write, mem_read);
    end
    checks++;
    if (p0_ack && p1_ack) begin
      errors++;
      $display("FAIL ack_excl: p0_ack=%b p1_ack=%b, required not both 1", p0_ack, p1_ack);
    end
    if (mem_write) wr_cnt++;
    if (mem_read)  rd_cnt++;
  endtask

  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Single transaction on one port: latency, err, rdata and the other ack.
  task automatic do_txn(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_rdata, input string name);
    int  n;
    bit  got;
    logic        err_s;
    logic [31:0] rd_s;
    n = 0;
    got = 0;
    err_s = 1'b0;
    rd_s = '0;
    set_port(port, 1'b1, we, addr, wdata);
    while (!got && n < 10) begin
      step();
      n++;
      if ((port == 0) ? p0_ack : p1_ack) begin
        got   = 1;
        err_s = (port == 0) ? p0_err : p1_err;
        rd_s  = (port == 0) ? p0_rdata : p1_rdata;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no ack within %0d cycles", name, n);
    end else begin
      if (n !== exp_lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_lat);
      end
      checks++;
      if (err_s !== exp_err) begin
        errors++;
        $display("FAIL %s_err: got %b, required %b", name, err_s, exp_err);
      end
      checks++;
      if (rd_s !== exp_rdata) begin
        errors++;
        $display("FAIL %s_rdata: got %h, required %h", name, rd_s, exp_rdata);
      end
    end
    set_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_reset();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({p0_ack, p1_ack, p0_err, p1_err, mem_write, mem_read, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ack/err/strobe/busy=%b, required 0000000",
               {p0_ack, p1_ack, p0_err, p1_err, mem_write, mem_read, busy});
    end
    checks++;
    if ({p0_rdata, p1_rdata, mem_addr, mem_wdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: rdata0=%h rdata1=%h mem_addr=%h mem_wdata=%h, required all 0",
               p0_rdata, p1_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_p0_write_read();
    int wr0;
    wr0 = wr_cnt;
    set_port(0, 1'b1, 1'b1, 32'h0, 32'hDEADBEEF);
    step();
    checks++;
    if ({mem_write, mem_read, busy} !== 3'b101 || mem_addr !== 32'h0 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL issue_cycle: write=%b read=%b busy=%b addr=%h wdata=%h, required 1 0 1 0 deadbeef",
               mem_write, mem_read, busy, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if ({mem_write, mem_read, p0_ack} !== 3'b000) begin
      errors++;
      $display("FAIL wait_cycle: write=%b read=%b ack=%b, required 000", mem_write, mem_read, p0_ack);
    end
    step();
    checks++;
    if ({p0_ack, p0_err, p1_ack} !== 3'b100 || p0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL p0_write_ack: ack=%b err=%b p1_ack=%b rdata=%h, required 1 0 0 0",
               p0_ack, p0_err, p1_ack, p0_rdata);
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if (p0_ack !== 1'b0 || (wr_cnt - wr0) !== 1) begin
      errors++;
      $display("FAIL p0_write_once: ack=%b writes=%0d, required 0 and 1", p0_ack, wr_cnt - wr0);
    end
    do_txn(0, 1'b0, 32'h0, 32'h0, 3, 1'b0, 32'hDEADBEEF, "p0_read0");
  endtask

  task automatic test_cross_port();
    int rd0, wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    do_txn(1, 1'b1, 32'h8, 32'h12345678, 3, 1'b0, 32'h0, "p1_write8");
    do_txn(0, 1'b0, 32'h8, 32'h0, 3, 1'b0, 32'h12345678, "p0_read8");
    checks++;
    if ((rd_cnt - rd0) !== 1 || (wr_cnt - wr0) !== 1) begin
      errors++;
      $display("FAIL cross_strobes: reads=%0d writes=%0d, required 1 and 1", rd_cnt - rd0, wr_cnt - wr0);
    end
  endtask

  task automatic test_tie_alternate();
    int ack_port [4];
    int ack_cyc  [4];
    int exp_port [4] = '{0, 1, 0, 1};
    int exp_cyc  [4] = '{3, 7, 11, 15};
    int na;
    na = 0;
    apply_reset();
    set_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      step();
      if ((p0_ack || p1_ack) && na < 4) begin
        ack_port[na] = p1_ack ? 1 : 0;
        ack_cyc[na]  = c;
        checks++;
        if ((p1_ack ? p1_rdata : p0_rdata) !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL tie_rdata%0d: got %h, required deadbeef", na,
                   p1_ack ? p1_rdata : p0_rdata);
        end
        na++;
      end
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (na !== 4) begin
      errors++;
      $display("FAIL tie_count: got %0d acks, required 4", na);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_port[i] !== exp_port[i] || ack_cyc[i] !== exp_cyc[i]) begin
          errors++;
          $display("FAIL tie_order%0d: got port %0d at cycle %0d, required port %0d at cycle %0d",
                   i, ack_port[i], ack_cyc[i], exp_port[i], exp_cyc[i]);
        end
      end
    end
    step();
    step();
  endtask

  task automatic test_errors();
    int rd0, wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    // Restore a known read value in port 0 so the forced-zero rdata is visible.
    do_txn(0, 1'b0, 32'h8, 32'h0, 3, 1'b0, 32'h12345678, "p0_read8b");
    rd0 = rd_cnt;
    do_txn(0, 1'b0, 32'h4, 32'h0, 1, 1'b1, 32'h0, "p0_err4");
    do_txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 1, 1'b1, 32'h0, "p1_err16");
    checks++;
    if ((rd_cnt - rd0) !== 0 || (wr_cnt - wr0) !== 0) begin
      errors++;
      $display("FAIL err_no_strobe: reads=%0d writes=%0d, required 0 and 0", rd_cnt - rd0, wr_cnt - wr0);
    end
    checks++;
    if (p0_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rdata_hold: got %h, required 12345678", p0_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  got0, got1;
    set_port(1, 1'b1, 1'b0, 32'h8, 32'h0);
    step();
    step();
    checks++;
    if (busy !== 1'b1 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_state: busy=%b mem_read=%b, required 1 0", busy, mem_read);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, p1_ack, mem_read, mem_write} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_abort: busy=%b ack=%b read=%b write=%b, required 0000",
               busy, p1_ack, mem_read, mem_write);
    end
    step();
    checks++;
    if (p1_ack !== 1'b0 || p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_noack: ack=%b rdata=%h, required 0 0", p1_ack, p1_rdata);
    end
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    set_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h0, 32'h0);
    n = 0;
    got0 = 0;
    got1 = 0;
    while (!got0 && !got1 && n < 10) begin
      step();
      n++;
      got0 = p0_ack;
      got1 = p1_ack;
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (!got0 || got1 || n !== 3) begin
      errors++;
      $display("FAIL post_reset_tie: p0=%b p1=%b cycle=%0d, required p0 first at cycle 3", got0, got1, n);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_p0_write_read();
    test_cross_port();
    test_tie_alternate();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
